seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: cycles a digit select and segment pattern must hold unchanged before capture (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000: cycles without any capture before the stale flag asserts (fits 24 bits).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port seg, input, 8: active-low segments, bit7=a ... bit1=g, bit0=dp.
REQ-006 SHALL have port dig, input, 4: active-low one-hot digit select; bit3 = leftmost (position 3), bit0 = position 0.
REQ-007 SHALL have port bcd, output, 16: last complete frame, {pos3,pos2,pos1,pos0}, 4-bit code each.
REQ-008 SHALL have port dp, output, 4: last complete frame decimal points, 1 = lit, bit n = position n.
REQ-009 SHALL have port frame_done, output, 1: one-cycle pulse when bcd/dp update.
REQ-010 SHALL have port seg_err, output, 1: one-cycle pulse on capture of an undecodable pattern.
REQ-011 SHALL have port dig_err, output, 1: one-cycle pulse when dig holds a stable illegal value (more than one bit low).
REQ-012 SHALL have port stale, output, 1: level, scan activity lost.

Function
REQ-013 SHALL decode seg[7:1] as: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hA (blank); any other pattern ->4'hF.
REQ-014 SHALL register seg and dig once (1-cycle input stage) before all comparisons.
REQ-015 SHALL run FSM states IDLE, SETTLE, HELD.
REQ-016 IDLE: dig = 4'b1111 or illegal; move to SETTLE when registered dig is exactly one bit low.
REQ-017 SETTLE: count cycles with seg and dig both unchanged; any change restarts count (new legal dig stays SETTLE, 1111 or illegal -> IDLE); at count == SETTLE_CYC capture code into slot of selected position, set that position's mask bit, go HELD.
REQ-018 HELD: no further capture; leave on any change of dig or seg (to SETTLE if legal one-hot, else IDLE).
REQ-019 Illegal dig stable for SETTLE_CYC cycles SHALL pulse dig_err once per occurrence, capture nothing.
REQ-020 Capture of code 4'hF SHALL pulse seg_err in the capture cycle; code still stored.
REQ-021 Recapture of an already-masked position before frame completes SHALL overwrite its slot.
REQ-022 When the mask reaches 4'b1111, the cycle after the completing capture SHALL load bcd/dp from slots, pulse frame_done, clear mask.
REQ-023 A capture coinciding with the frame load cycle SHALL land in the new frame (mask bit set after clear).
REQ-024 Timeout counter SHALL clear on every capture, otherwise increment saturating; stale = 1 when counter >= TIMEOUT_CYC, 0 on next capture.
REQ-025 bcd/dp SHALL hold last frame while stale; never partially updated.

Reset
REQ-026 While rst = 0: FSM IDLE, counters 0, mask 0, slots 4'hA, bcd = 16'hAAAA, dp = 0, frame_done = seg_err = dig_err = 0, stale = 0.
REQ-027 Reset asserted mid-frame SHALL discard partial slots; first frame_done after release requires four fresh captures.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge; no output glitch on release.

Configuration
REQ-029 Macro SEG_SCAN_DECODER_DP_CAPTURE_EN defined: dp bit n captured as ~seg[0] with the position-n digit and frame-loaded with bcd.
REQ-030 Macro undefined: seg[0] ignored, no dp slot storage, dp output constant 4'b0000; all other behaviour identical.

Verification
REQ-031 Scan "1234" (dig 0111,1011,1101,1110 with codes 1,2,3,4), 50 cycles each, SETTLE_CYC=16 -> one frame_done, bcd = 16'h1234, no errors.
REQ-032 Hold position 2 only 10 cycles (< SETTLE_CYC) inside a scan -> no capture, no frame_done until position 2 held >= 16 cycles.
REQ-033 seg = 8'b01101101 on position 0 for 50 cycles -> seg_err pulse, next frame bcd[3:0] = 4'hF; dig = 4'b0011 for 50 cycles -> one dig_err pulse.
REQ-034 Stop scanning (dig = 1111) with TIMEOUT_CYC=1000 -> stale = 1 after 1000 cycles, bcd unchanged; resume scan -> stale = 0 on first capture.
REQ-035 Assert rst after 3 of 4 digits captured, release, scan "5678" -> single frame_done, bcd = 16'h5678.
REQ-036 With DP_CAPTURE_EN, seg[0] = 0 on position 1 -> dp = 4'b0010; without macro -> dp = 4'b0000.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Recovers the digits shown on a multiplexed, active-low 7-segment display by
// watching its segment and digit-select lines. Each digit position is captured
// once its select and segment pattern have been steady for SETTLE_CYC cycles.
// When all four positions are captured, the whole frame is published at once.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   seg[7:0]   : active-low segments, bit7=a ... bit1=g, bit0=dp
//   dig[3:0]   : active-low one-hot digit select, bit3 = leftmost position
//   bcd[15:0]  : last complete frame {pos3,pos2,pos1,pos0}
//   dp[3:0]    : last complete frame decimal points (1 = lit)
//   frame_done : one-cycle pulse when bcd/dp update
//   seg_err    : one-cycle pulse when an undecodable pattern is captured
//   dig_err    : one-cycle pulse when an illegal select stays stable
//   stale      : level, no capture for TIMEOUT_CYC cycles
//
// Build option
//   SEG_SCAN_DECODER_DP_CAPTURE_EN : capture decimal points per position and
//                                    publish them with the frame; otherwise
//                                    dp is constant 4'b0000.
module seg_scan_decoder #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig,
    output logic [15:0] bcd,
    output logic [3:0]  dp,
    output logic        frame_done,
    output logic        seg_err,
    output logic        dig_err,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYC);
    localparam logic [23:0] TMO_LIM    = 24'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b1111111: code = 4'hA;
            default:    code = 4'hF;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot_low(input logic [3:0] d);
        logic ok;
        case (d)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] pos_of(input logic [3:0] d);
        logic [1:0] p;
        case (d)
            4'b0111: p = 2'd3;
            4'b1011: p = 2'd2;
            4'b1101: p = 2'd1;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  seg_q, seg_d, seg_last_q, seg_last_d;
    logic [3:0]  dig_q, dig_d, dig_last_q, dig_last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dig_err_seen_q, dig_err_seen_d;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] bcd_q, bcd_d;
    logic        frame_done_q, frame_done_d;
    logic        seg_err_q, seg_err_d;
    logic        dig_err_q, dig_err_d;
    logic [23:0] tmo_q, tmo_d;
    logic        stale_q, stale_d;
    logic [7:0]  cnt_inc_s;
    logic        chg_s;
    logic        legal_s;
    logic        capture_s;
    logic [1:0]  cap_pos_s;
    logic [3:0]  cap_code_s;
`ifdef SEG_SCAN_DECODER_DP_CAPTURE_EN
    logic [3:0]  dp_slot_q, dp_slot_d;
    logic [3:0]  dp_q, dp_d;
`endif

    assign cnt_inc_s = cnt_q + 8'd1;

    // Next-state, capture, frame assembly and timeout logic
    always_comb begin
        seg_d          = seg;
        dig_d          = dig;
        seg_last_d     = seg_q;
        dig_last_d     = dig_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        dig_err_seen_d = dig_err_seen_q;
        slot_d         = slot_q;
        mask_d         = mask_q;
        bcd_d          = bcd_q;
        frame_done_d   = 1'b0;
        seg_err_d      = 1'b0;
        dig_err_d      = 1'b0;
        capture_s      = 1'b0;
        cap_pos_s      = pos_of(dig_q);
        cap_code_s     = decode_seg(seg_q[7:1]);
        chg_s          = (dig_q != dig_last_q) || (seg_q != seg_last_q);
        legal_s        = is_onehot_low(dig_q);
`ifdef SEG_SCAN_DECODER_DP_CAPTURE_EN
        dp_slot_d      = dp_slot_q;
        dp_d           = dp_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (legal_s) begin
                    state_d        = ST_SETTLE;
                    cnt_d          = 8'd0;
                    dig_err_seen_d = 1'b0;
                end else if ((dig_q == 4'b1111) || (dig_q != dig_last_q)) begin
                    cnt_d          = 8'd0;
                    dig_err_seen_d = 1'b0;
                end else if (!dig_err_seen_q) begin
                    // Stable illegal select: report once, then stay quiet
                    // until the select changes.
                    if (cnt_inc_s == SETTLE_LIM) begin
                        dig_err_d      = 1'b1;
                        dig_err_seen_d = 1'b1;
                        cnt_d          = 8'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SETTLE: begin
                if (chg_s) begin
                    cnt_d = 8'd0;
                    if (legal_s) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d        = ST_IDLE;
                        dig_err_seen_d = 1'b0;
                    end
                end else if (cnt_inc_s == SETTLE_LIM) begin
                    capture_s = 1'b1;
                    state_d   = ST_HELD;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_HELD: begin
                if (chg_s) begin
                    cnt_d = 8'd0;
                    if (legal_s) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d        = ST_IDLE;
                        dig_err_seen_d = 1'b0;
                    end
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Publish a full frame one cycle after it completes; a capture in the
        // same cycle belongs to the next frame, so the mask clears first.
        if (mask_q == 4'b1111) begin
            bcd_d        = slot_q;
            frame_done_d = 1'b1;
            mask_d       = 4'b0000;
`ifdef SEG_SCAN_DECODER_DP_CAPTURE_EN
            dp_d         = dp_slot_q;
`endif
        end else begin
            mask_d = mask_q;
        end

        if (capture_s) begin
            slot_d[{cap_pos_s, 2'b00} +: 4] = cap_code_s;
            mask_d[cap_pos_s]               = 1'b1;
            seg_err_d                       = (cap_code_s == 4'hF);
`ifdef SEG_SCAN_DECODER_DP_CAPTURE_EN
            dp_slot_d[cap_pos_s]            = ~seg_q[0];
`endif
            tmo_d                           = 24'd0;
        end else if (tmo_q != 24'hFFFFFF) begin
            tmo_d = tmo_q + 24'd1;
        end else begin
            tmo_d = tmo_q;
        end

        stale_d = (tmo_d >= TMO_LIM);
    end

    // State, input stage and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            seg_q          <= 8'hFF;
            dig_q          <= 4'hF;
            seg_last_q     <= 8'hFF;
            dig_last_q     <= 4'hF;
            cnt_q          <= 8'd0;
            dig_err_seen_q <= 1'b0;
            slot_q         <= 16'hAAAA;
            mask_q         <= 4'b0000;
            bcd_q          <= 16'hAAAA;
            frame_done_q   <= 1'b0;
            seg_err_q      <= 1'b0;
            dig_err_q      <= 1'b0;
            tmo_q          <= 24'd0;
            stale_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_q          <= seg_d;
            dig_q          <= dig_d;
            seg_last_q     <= seg_last_d;
            dig_last_q     <= dig_last_d;
            cnt_q          <= cnt_d;
            dig_err_seen_q <= dig_err_seen_d;
            slot_q         <= slot_d;
            mask_q         <= mask_d;
            bcd_q          <= bcd_d;
            frame_done_q   <= frame_done_d;
            seg_err_q      <= seg_err_d;
            dig_err_q      <= dig_err_d;
            tmo_q          <= tmo_d;
            stale_q        <= stale_d;
        end
    end

`ifdef SEG_SCAN_DECODER_DP_CAPTURE_EN
    // Decimal-point slot and frame registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_slot_q <= 4'b0000;
            dp_q      <= 4'b0000;
        end else begin
            dp_slot_q <= dp_slot_d;
            dp_q      <= dp_d;
        end
    end
    assign dp = dp_q;
`else
    assign dp = 4'b0000;
`endif

    assign bcd        = bcd_q;
    assign frame_done = frame_done_q;
    assign seg_err    = seg_err_q;
    assign dig_err    = dig_err_q;
    assign stale      = stale_q;

endmodule
